bcd_sub_result_disp: RTL and testbench
======================================

// Module: bcd_sub_result_disp
// PURPOSE
//  Downstream stage of the single-digit BCD subtractor. Takes each {diff, borrow} result
//  over a valid/ready handshake and converts it to sign/magnitude. Drives a 2-digit
//  multiplexed 7-segment display: sign digit plus magnitude digit.
//  Enforces a minimum display time per result so each difference stays visible on the board.
// PARAMETERS
//  REFRESH_DIV     100000  clk cycles per digit scan slot (>=2)
//  MIN_HOLD        50000000  clk cycles in_ready stays low after a capture (>=1)
//  SEG_ACTIVE_LOW  1       1: seg/an outputs active-low; 0: active-high
// PORTS
//  clk        in   1  system clock, all logic rising-edge
//  rst_n      in   1  asynchronous active-low reset
//  clr        in   1  synchronous clear: blank display, return to IDLE
//  in_valid   in   1  upstream result valid
//  in_ready   out  1  block can accept a result this cycle
//  diff_in    in   4  BCD difference digit from subtractor
//  borrow_in  in   1  1 = result negative; diff_in holds the 10's complement
//  sign       out  1  registered sign of captured result (1 = negative)
//  mag        out  4  registered BCD magnitude of captured result
//  err        out  1  captured result not representable
//  seg        out  7  segments {g,f,e,d,c,b,a}
//  an         out  2  digit enables; an[0] = magnitude digit, an[1] = sign digit
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sign=0, mag=0, err=0, scan counter=0,
//   digit_sel=0, hold counter=0, in_ready=0 while rst_n low.
//   All segments and anodes are inactive (per SEG_ACTIVE_LOW).
//  Transfer: occurs on a clk edge with in_valid && in_ready. Only then are sign/mag/err loaded.
//   They are valid from the following cycle (1-cycle latency).
//  in_ready = (state==IDLE || state==SHOW) && !clr. No combinational path from in_valid to in_ready.
//  FSM:
//   IDLE: display blank. Transfer -> HOLD, hold counter loaded with MIN_HOLD-1.
//   HOLD: display active, in_ready=0. Counter decrements; at 0 -> SHOW.
//   SHOW: display active, in_ready=1. Transfer -> recapture, back to HOLD, counter reloaded.
//   clr=1 in any state -> IDLE next cycle. clr takes priority: no transfer can occur
//    because in_ready is forced 0, so no data is lost. sign/mag/err are cleared to 0.
//  Conversion (on capture):
//   diff_in > 9                  -> err=1, sign=0, mag=0
//   borrow_in=1 && diff_in==0    -> err=1 (value -10 out of range), sign=0, mag=0
//   borrow_in=0                  -> sign=0, mag=diff_in
//   borrow_in=1                  -> sign=1, mag=10-diff_in (e.g. 9 -> 1, 6 -> 4)
//  Scan: counter runs 0..REFRESH_DIV-1 in all states and wraps to 0.
//   digit_sel toggles on each wrap. Only one an bit is active at a time; both are inactive in IDLE.
//  Digit content (active-high gfedcba, inverted at output if SEG_ACTIVE_LOW):
//   digit_sel=0: err ? 'E'(1111001) : mag decoded 0-9 (0=0111111, 1=0000110, ... 9=1101111)
//   digit_sel=1: (sign && !err) ? '-'(1000000) : blank(0000000)
//  seg and an are registered; they change only on clk edges, with no glitches between digits.
//  rst_n asserted mid-HOLD/SHOW: immediate blank, FSM to IDLE. The capture in progress is discarded.
// TESTING (bench params: REFRESH_DIV=4, MIN_HOLD=3, SEG_ACTIVE_LOW=0)
//  1. Reset then idle 20 cycles -> an=00, seg=0, in_ready=1 after release, sign/mag/err=0.
//  2. Send diff=1,borrow=0 (3-2) -> next cycle sign=0, mag=1.
//     an[0] slot seg=0000110, an[1] slot blank. in_ready low exactly 3 cycles.
//  3. Send diff=9,borrow=1 (8-9) -> sign=1, mag=1. an[1] slot shows 1000000.
//     Also send diff=9,borrow=1 (4-5) -> same result.
//  4. Send diff=1010 (invalid), then diff=0,borrow=1 -> err=1 both times, mag=0.
//     an[0] slot shows 1111001, an[1] slot blank.
//  5. Hold in_valid high with a new value during HOLD -> no capture until SHOW.
//     Assert clr coincident with in_valid in SHOW -> no capture, IDLE, display blank.
//  6. Pulse rst_n low mid-HOLD -> outputs clear immediately, async.
//     Scan alternates an 01/10 every 4 cycles after a new capture.

Source files
------------

// File: rtl/bcd_sub_result_disp_if.sv
// Handshake bundle between the BCD subtractor and its result display stage.
//   in_valid  : upstream result valid
//   in_ready  : display stage can accept a result this cycle
//   diff_in   : BCD difference digit (10's complement when borrow_in=1)
//   borrow_in : 1 = result negative
// master = upstream subtractor, slave = display stage.
interface bcd_sub_result_disp_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] diff_in;
    logic       borrow_in;

    modport master (output in_valid, output diff_in, output borrow_in, input in_ready);
    modport slave  (input in_valid, input diff_in, input borrow_in, output in_ready);
endinterface

// File: rtl/bcd_sub_result_disp.sv
// Result display stage for a single-digit BCD subtractor.
// Captures {diff, borrow} over a valid/ready handshake, converts it to
// sign/magnitude (flagging unrepresentable values) and scans it onto a
// 2-digit multiplexed 7-segment display. After each capture the block
// refuses new data for MIN_HOLD cycles so every result stays readable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (blank display, back to IDLE)
//   bus        : handshake bundle (slave side)
//   sign/mag/err : registered sign/magnitude of the last captured result
//   seg        : segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an         : digit enables, an[0] = magnitude digit, an[1] = sign digit
module bcd_sub_result_disp #(
    parameter int REFRESH_DIV    = 100000,
    parameter int MIN_HOLD       = 50000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    bcd_sub_result_disp_if.slave bus,
    output logic                 sign,
    output logic [3:0]           mag,
    output logic                 err,
    output logic [6:0]           seg,
    output logic [1:0]           an
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [1:0] AN_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

    state_t          state_r;
    logic [HW-1:0]   hold_r;
    logic [SW-1:0]   scan_r;
    logic            digit_sel_r;
    logic            run_r;
    logic            sign_r;
    logic [3:0]      mag_r;
    logic            err_r;
    logic [6:0]      seg_r;
    logic [1:0]      an_r;
    logic            xfer_s;
    logic [5:0]      conv_s;
    logic [6:0]      seg_s;
    logic [1:0]      an_s;

    // Returns {err, sign, mag} for a raw subtractor result.
    function automatic logic [5:0] convert(input logic [3:0] d, input logic b);
        logic [5:0] r;
        if (d > 4'd9) begin
            r = 6'b10_0000;
        end else if (b && (d == 4'd0)) begin
            r = 6'b10_0000;           // -10 has no single-digit magnitude
        end else if (b) begin
            r = {1'b0, 1'b1, 4'd10 - d};
        end else begin
            r = {1'b0, 1'b0, d};
        end
        return r;
    endfunction

    // Active-high gfedcba pattern for a BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // run_r keeps in_ready low during reset and for the first edge after it.
    assign bus.in_ready = run_r && ((state_r == IDLE) || (state_r == SHOW)) && !clr;
    assign xfer_s       = bus.in_valid && bus.in_ready;
    assign conv_s       = convert(bus.diff_in, bus.borrow_in);

    assign sign = sign_r;
    assign mag  = mag_r;
    assign err  = err_r;
    assign seg  = seg_r;
    assign an   = an_r;

    // Out-of-reset marker gating in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Capture FSM: IDLE -> HOLD (minimum display time) -> SHOW (accepting).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hold_r  <= '0;
            sign_r  <= 1'b0;
            mag_r   <= 4'd0;
            err_r   <= 1'b0;
        end else if (clr) begin
            state_r <= IDLE;
            hold_r  <= '0;
            sign_r  <= 1'b0;
            mag_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, SHOW: begin
                    if (xfer_s) begin
                        err_r   <= conv_s[5];
                        sign_r  <= conv_s[4];
                        mag_r   <= conv_s[3:0];
                        hold_r  <= HW'(MIN_HOLD - 1);
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_r == '0) begin
                        state_r <= SHOW;
                    end else begin
                        hold_r <= hold_r - 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Free-running scan slot counter; digit select flips on every wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_r      <= '0;
            digit_sel_r <= 1'b0;
        end else if (scan_r == SW'(REFRESH_DIV - 1)) begin
            scan_r      <= '0;
            digit_sel_r <= ~digit_sel_r;
        end else begin
            scan_r <= scan_r + 1'b1;
        end
    end

    // Next display pattern, active-high, then polarity applied.
    always_comb begin
        seg_s = 7'b0000000;
        an_s  = 2'b00;
        if (state_r != IDLE) begin
            if (!digit_sel_r) begin
                an_s  = 2'b01;
                seg_s = err_r ? 7'b1111001 : seg_decode(mag_r);
            end else begin
                an_s  = 2'b10;
                seg_s = (sign_r && !err_r) ? 7'b1000000 : 7'b0000000;
            end
        end else begin
            an_s  = 2'b00;
            seg_s = 7'b0000000;
        end
        if (SEG_ACTIVE_LOW) begin
            seg_s = ~seg_s;
            an_s  = ~an_s;
        end else begin
            seg_s = seg_s;
            an_s  = an_s;
        end
    end

    // Registered display drive so digits switch cleanly on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
        end else if (clr) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

endmodule

// File: tb/tb_bcd_sub_result_disp.sv
module tb_bcd_sub_result_disp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       sign;
    logic [3:0] mag;
    logic       err;
    logic [6:0] seg;
    logic [1:0] an;

    int total = 0;
    int bad   = 0;
    logic [5:0] expq[$];

    localparam logic [6:0] SEGT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    bcd_sub_result_disp_if bus ();

    bcd_sub_result_disp #(
        .REFRESH_DIV(4), .MIN_HOLD(3), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave),
        .sign(sign), .mag(mag), .err(err), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each observed handshake pops one expected result.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                @(posedge clk);
                #1;
                if (expq.size() == 0) begin
                    chk("unexpected_capture", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("cap_err",  int'(err),  int'(e[5]));
                    chk("cap_sign", int'(sign), int'(e[4]));
                    chk("cap_mag",  int'(mag),  int'(e[3:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+2; returns with in_valid low at posedge+2 after the handshake.
    task automatic send(input logic [3:0] d, input logic b, input logic es,
                        input logic [3:0] em, input logic ee, output int lows);
        bit ok;
        bus.in_valid  = 1'b1;
        bus.diff_in   = d;
        bus.borrow_in = b;
        expq.push_back({ee, es, em});
        lows = 0;
        ok   = 1'b0;
        while (!ok && lows <= 50) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else lows++;
        end
        if (!ok) begin
            chk("handshake_timeout", 0, 1);
            void'(expq.pop_back());
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    // Scans several slots and checks each lit digit.
    task automatic check_disp(input logic [6:0] lo, input logic [6:0] hi, input string tag);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (an == 2'b01) chk({tag, "_lo_seg"}, int'(seg), int'(lo));
            else if (an == 2'b10) chk({tag, "_hi_seg"}, int'(seg), int'(hi));
            else chk({tag, "_an_onehot"}, int'(an), 1);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int lows;
        int run;
        bit changed;
        logic [1:0] prev_an;
        bus.in_valid  = 1'b0;
        bus.diff_in   = 4'd0;
        bus.borrow_in = 1'b0;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.in_ready), 0);
        chk("rst_an", int'(an), 0);
        chk("rst_seg", int'(seg), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_an", int'(an), 0);
        chk("idle_seg", int'(seg), 0);
        chk("idle_ready", int'(bus.in_ready), 1);
        chk("idle_sign", int'(sign), 0);
        chk("idle_mag", int'(mag), 0);
        chk("idle_err", int'(err), 0);
        @(posedge clk);
        #2;

        // 2. 3-2 = +1, ready stays low for the hold time
        send(4'd1, 1'b0, 1'b0, 4'd1, 1'b0, lows);
        lows = 0;
        while (!bus.in_ready && lows < 50) begin
            @(negedge clk);
            if (!bus.in_ready) lows++;
        end
        chk("hold_low_cycles", lows, 3);
        @(posedge clk);
        #2;
        check_disp(SEGT[1], SEG_BLANK, "pos1");

        // 3. 8-9 and 4-5 both give -1
        send(4'd9, 1'b1, 1'b1, 4'd1, 1'b0, lows);
        check_disp(SEGT[1], SEG_MINUS, "neg1a");
        send(4'd9, 1'b1, 1'b1, 4'd1, 1'b0, lows);
        check_disp(SEGT[1], SEG_MINUS, "neg1b");

        // 4. invalid digit and -10
        send(4'b1010, 1'b0, 1'b0, 4'd0, 1'b1, lows);
        check_disp(SEG_E, SEG_BLANK, "err_inv");
        send(4'd0, 1'b1, 1'b0, 4'd0, 1'b1, lows);
        check_disp(SEG_E, SEG_BLANK, "err_m10");
        send(4'd6, 1'b1, 1'b1, 4'd4, 1'b0, lows);

        // 5. valid held through HOLD, then clr against valid in SHOW
        send(4'd2, 1'b0, 1'b0, 4'd2, 1'b0, lows);
        send(4'd7, 1'b1, 1'b1, 4'd3, 1'b0, lows);
        chk("held_valid_wait", lows, 3);
        check_disp(SEGT[3], SEG_MINUS, "neg3");
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.diff_in  = 4'd5;
        bus.borrow_in = 1'b0;
        @(negedge clk);
        chk("clr_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #2;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_sign", int'(sign), 0);
        chk("clr_mag", int'(mag), 0);
        repeat (3) @(negedge clk);
        chk("clr_an", int'(an), 0);
        chk("clr_seg", int'(seg), 0);
        @(posedge clk);
        #2;

        // 6. async reset mid-HOLD
        send(4'd5, 1'b0, 1'b0, 4'd5, 1'b0, lows);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_mag", int'(mag), 0);
        chk("arst_an", int'(an), 0);
        chk("arst_seg", int'(seg), 0);
        chk("arst_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // scan alternation after a fresh capture
        send(4'd4, 1'b0, 1'b0, 4'd4, 1'b0, lows);
        repeat (2) @(negedge clk);
        prev_an = an;
        run = 1;
        changed = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (an == 2'b01) chk("scan_lo_seg", int'(seg), int'(SEGT[4]));
            else if (an == 2'b10) chk("scan_hi_seg", int'(seg), int'(SEG_BLANK));
            else chk("scan_an_onehot", int'(an), 1);
            if (an != prev_an) begin
                if (changed) chk("scan_slot_len", run, 4);
                changed = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            prev_an = an;
        end

        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
